tanh4_share_sched: RTL and testbench

Round-robin scheduler that shares one approximate 4-bit tanh core among NREQ independent requesters. Each cycle it grants at most one requester, registers that operand, evaluates it in the shared core, and returns a registered result tagged with the requester index. It sits between the activation-function consumers of a small NN datapath and the single area-optimised tanh instance. Backpressure comes from a single result port.

---
 rtl/tanh4_share_pkg.sv | 15 +
 rtl/tanh4_share_sched_core.sv | 16 +
 rtl/tanh4_share_sched.sv | 131 +++++++++++++
 tb/tb_tanh4_share_sched.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tanh4_share_pkg.sv
// Shared types and widths for the tanh4 sharing scheduler.
// Stage-register bundle and perf counter width live here.
package tanh4_share_pkg;

   localparam int DW      = 4;
   localparam int PERF_W  = 16;
   localparam int ID_MAXW = 4;

   typedef struct packed {
      logic [DW-1:0]      data;
      logic [ID_MAXW-1:0] id;
      logic               vld;
   } stage_t;

endpackage

// File: rtl/tanh4_share_sched_core.sv
// Combinational 4-bit approximate tanh core.
// Shared by all requesters through the scheduler pipeline.
module tanh4_approx_core (
   input  logic [3:0] d,
   output logic [3:0] r
);

   logic n;

   assign n    = ~(d[1] & d[0]);
   assign r[0] = d[0];
   assign r[1] = d[0];
   assign r[2] = ~((d[2] | n) ^ d[1]);
   assign r[3] = ~(d[1] ^ (d[3] | n));

endmodule

// File: rtl/tanh4_share_sched.sv
// Round-robin scheduler sharing one tanh4 core among NREQ requesters.
// Optional perf counters: define TANH4_SHARE_PERF_EN.
module tanh4_share_sched
   import tanh4_share_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [4*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_data,
`ifdef TANH4_SHARE_PERF_EN
   output logic [IDW-1:0]    out_id,
   output logic [PERF_W-1:0] perf_busy_cnt,
   output logic [PERF_W-1:0] perf_stall_cnt
`else
   output logic [IDW-1:0]    out_id
`endif
);

   stage_t         s1;
   stage_t         s2;
   logic           adv1;
   logic           adv2;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] win;
   logic           found;
   logic           xfer;
   logic [DW-1:0]  operand;
   logic [DW-1:0]  core_r;
   logic           unused_id;

   assign adv2 = ~s2.vld | out_ready;
   assign adv1 = ~s1.vld | adv2;
   assign xfer = found & adv1;

   // Round-robin search: first valid requester at or after ptr
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = idx[IDW-1:0];
         end
      end
   end

   // Grant is one-hot on the winner, only when S1 can accept
   always_comb begin
      req_ready = '0;
      if (found) req_ready[win] = adv1;
   end

   assign operand = req_data[int'(win)*DW +: DW];

   // Pointer moves past the requester that just transferred
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (xfer) begin
         if (int'(win) == NREQ-1) ptr <= '0;
         else ptr <= win + IDW'(1);
      end
   end

   // S1: captured operand and requester index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
      end else if (adv1) begin
         s1.vld <= xfer;
         if (xfer) begin
            s1.data <= operand;
            s1.id   <= ID_MAXW'(win);
         end
      end
   end

   tanh4_approx_core u_core (
      .d (s1.data),
      .r (core_r)
   );

   // S2: registered result, held while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2 <= '0;
      end else if (adv2) begin
         s2.vld <= s1.vld;
         if (s1.vld) begin
            s2.data <= core_r;
            s2.id   <= s1.id;
         end
      end
   end

   assign out_valid = s2.vld;
   assign out_data  = s2.data;
   assign out_id    = s2.id[IDW-1:0];
   assign unused_id = ^s2.id;

`ifdef TANH4_SHARE_PERF_EN
   // Saturating count of cycles with any stage occupied
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_busy_cnt <= '0;
      end else if ((s1.vld | s2.vld) && (perf_busy_cnt != '1)) begin
         perf_busy_cnt <= perf_busy_cnt + PERF_W'(1);
      end
   end

   // Saturating count of cycles where the result is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
      end else if (s2.vld && !out_ready && (perf_stall_cnt != '1)) begin
         perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_tanh4_share_sched.sv
// Directed bench for tanh4_share_sched (NREQ = 4).
// Inputs change on negedge; outputs sampled 1ns later.
module tb_tanh4_share_sched;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_data;
   logic [1:0]  out_id;
`ifdef TANH4_SHARE_PERF_EN
   logic [15:0] perf_busy_cnt;
   logic [15:0] perf_stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   tanh4_share_sched #(.NREQ(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_data       (req_data),
      .req_ready      (req_ready),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
`ifdef TANH4_SHARE_PERF_EN
      .out_id         (out_id),
      .perf_busy_cnt  (perf_busy_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`else
      .out_id         (out_id)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      req_valid = '0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ready got %b want 0000", req_ready);
      end
      checks++;
      if (out_valid !== 1'b0 || out_data !== 4'd0 || out_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_out got v%b d%b id%0d want v0 d0000 id0",
                  out_valid, out_data, out_id);
      end
`ifdef TANH4_SHARE_PERF_EN
      checks++;
      if (perf_busy_cnt !== 16'd0 || perf_stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_perf got %0d/%0d want 0/0",
                  perf_busy_cnt, perf_stall_cnt);
      end
`endif
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 4'b0001;
      req_data  = 16'h0003;
      out_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL single_grant got %b want 0001", req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_t1 got v%b want v0", out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'b0011 || out_id !== 2'd0) begin
         errors++;
         $display("FAIL single_t2 got v%b d%b id%0d want v1 d0011 id0",
                  out_valid, out_data, out_id);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_t3 got v%b want v0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ops [4];
      logic [3:0] exp [4];
      ops[0] = 4'b0000; exp[0] = 4'b0000;
      ops[1] = 4'b0101; exp[1] = 4'b0011;
      ops[2] = 4'b0111; exp[2] = 4'b0111;
      ops[3] = 4'b1111; exp[3] = 4'b1111;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 7; cyc++) begin
         @(negedge clk);
         if (cyc < 4) begin
            req_valid = 4'b0100;
            req_data  = {4'h0, ops[cyc], 8'h00};
         end else begin
            req_valid = '0;
         end
         #1;
         if (cyc < 4) begin
            checks++;
            if (req_ready !== 4'b0100) begin
               errors++;
               $display("FAIL b2b_grant c%0d got %b want 0100", cyc, req_ready);
            end
         end
         if (cyc >= 2 && cyc < 6) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[cyc-2] || out_id !== 2'd2) begin
               errors++;
               $display("FAIL b2b_out c%0d got v%b d%b id%0d want v1 d%b id2",
                        cyc, out_valid, out_data, out_id, exp[cyc-2]);
            end
         end
         if (cyc == 6) begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL b2b_tail got v%b want v0", out_valid);
            end
         end
         @(posedge clk);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp [4];
      logic [3:0] want;
      exp[0] = 4'b0011;
      exp[1] = 4'b0000;
      exp[2] = 4'b0111;
      exp[3] = 4'b1111;
      do_reset();
      req_data  = {4'b1111, 4'b0111, 4'b0000, 4'b0011};
      req_valid = 4'b1111;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         want = 4'b0001 << (k % 4);
         checks++;
         if (req_ready !== want) begin
            errors++;
            $display("FAIL rr_grant c%0d got %b want %b", k, req_ready, want);
         end
         if (k >= 2) begin
            checks++;
            if (out_valid !== 1'b1 || out_id !== 2'((k-2) % 4) ||
                out_data !== exp[(k-2) % 4]) begin
               errors++;
               $display("FAIL rr_out c%0d got v%b d%b id%0d want v1 d%b id%0d",
                        k, out_valid, out_data, out_id, exp[(k-2) % 4], (k-2) % 4);
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      req_valid = '0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [3:0] want_rdy;
      logic       want_v;
      logic [1:0] want_id;
      logic [3:0] exp [4];
      exp[0] = 4'b0011;
      exp[1] = 4'b0000;
      exp[2] = 4'b0111;
      exp[3] = 4'b1111;
      do_reset();
      req_data = {4'b1111, 4'b0111, 4'b0000, 4'b0011};
      for (int cyc = 0; cyc < 12; cyc++) begin
         req_valid = (cyc < 9) ? 4'b1111 : 4'b0000;
         out_ready = (cyc >= 7);
         #1;
         case (cyc)
            0: want_rdy = 4'b0001;
            1: want_rdy = 4'b0010;
            7: want_rdy = 4'b0100;
            8: want_rdy = 4'b1000;
            default: want_rdy = 4'b0000;
         endcase
         want_v  = (cyc >= 2 && cyc <= 10);
         want_id = (cyc <= 7) ? 2'd0 : 2'(cyc - 7);
         checks++;
         if (req_ready !== want_rdy) begin
            errors++;
            $display("FAIL bp_grant c%0d got %b want %b", cyc, req_ready, want_rdy);
         end
         checks++;
         if (out_valid !== want_v) begin
            errors++;
            $display("FAIL bp_valid c%0d got %b want %b", cyc, out_valid, want_v);
         end
         if (want_v) begin
            checks++;
            if (out_id !== want_id || out_data !== exp[want_id]) begin
               errors++;
               $display("FAIL bp_out c%0d got d%b id%0d want d%b id%0d",
                        cyc, out_data, out_id, exp[want_id], want_id);
            end
         end
`ifdef TANH4_SHARE_PERF_EN
         if (cyc == 7) begin
            checks++;
            if (perf_stall_cnt !== 16'd5 || perf_busy_cnt !== 16'd6) begin
               errors++;
               $display("FAIL bp_perf got stall%0d busy%0d want stall5 busy6",
                        perf_stall_cnt, perf_busy_cnt);
            end
         end
`endif
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req_data  = {4'b1111, 4'b0111, 4'b0101, 4'b0011};
      req_valid = 4'b1111;
      out_ready = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL ar_full got v%b want v1", out_valid);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 4'd0 || out_id !== 2'd0) begin
         errors++;
         $display("FAIL ar_clear got v%b d%b id%0d want v0 d0000 id0",
                  out_valid, out_data, out_id);
      end
      req_valid = 4'b1010;
      out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0010 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ar_first got rdy%b v%b want rdy0010 v0", req_ready, out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b1000 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ar_second got rdy%b v%b want rdy1000 v0", req_ready, out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 4'b0011) begin
         errors++;
         $display("FAIL ar_out1 got v%b d%b id%0d want v1 d0011 id1",
                  out_valid, out_data, out_id);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== 4'b1111) begin
         errors++;
         $display("FAIL ar_out3 got v%b d%b id%0d want v1 d1111 id3",
                  out_valid, out_data, out_id);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ar_tail got v%b want v0", out_valid);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_round_robin();
      test_backpressure();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
